seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the digital clock core's six BCD time digits and the alarm HH:MM readback.
- Time-multiplexes them onto a 6-digit common-anode seven-segment display.
- Scans one digit per refresh slot and snapshots inputs once per frame to prevent tearing.
- Inserts an anti-ghost blank cycle at the start of each slot and blinks the whole display while the alarm is sounding.

Parameters:
- REFRESH_DIV, 50000: clocks per digit slot; legal range is 2 or more.
- BLINK_DIV, 25000000: clocks per blink half-period; legal range is 2 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sec_r  in  4  BCD seconds ones
- sec_l  in  3  BCD seconds tens
- min_r  in  4  BCD minutes ones
- min_l  in  3  BCD minutes tens
- hr_r  in  4  BCD hours ones
- hr_l  in  2  BCD hours tens
- alm_hr_l  in  2  alarm hours tens
- alm_hr_r  in  4  alarm hours ones
- alm_min_l  in  3  alarm minutes tens
- alm_min_r  in  4  alarm minutes ones
- show_alarm  in  1  1 = display the alarm setting instead of the time
- alarm_active  in  1  alarm sounding; enables blink
- an  out  6  digit enables, active-low; an[0] = rightmost digit
- seg  out  7  segments, active-low; seg[6:0] = g,f,e,d,c,b,a
- dp  out  1  decimal point, active-low

Behaviour:
- Single clock, synchronous active-high reset. All outputs are registered.
- Reset values:
  - an=6'b111111, seg=7'b1111111, dp=1.
  - slot counter=0, scan index=0, blink counter=0, blink phase=1 (visible).
  - all snapshot registers=0.
- Slot counter runs 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, scan index advances 0,1,…,5, then back to 0.
- Snapshot registers (time digits, alarm digits, show_alarm):
  - Loaded on the wrap edge where scan index is 5, i.e. at the start of each frame.
  - Held constant for the rest of the frame.
  - Inputs changing mid-frame have no effect until the next frame.
- Digit source by scan index, time view (snapshot show_alarm=0):
  - 0 = sec_r, 1 = sec_l, 2 = min_r, 3 = min_l, 4 = hr_r, 5 = hr_l.
- Digit source by scan index, alarm view (snapshot show_alarm=1):
  - 2 = alm_min_r, 3 = alm_min_l, 4 = alm_hr_r, 5 = alm_hr_l.
  - Indices 0 and 1 are blank: an bit high, seg all 1.
- Narrow inputs are zero-extended to 4 bits before decode.
- Decode, seg active-low in gfedcba order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10–15 show a dash, 0111111.
- dp is low only on scan indices 2 and 4 (HH.MM.SS separators), and only while that digit is driven.
- Output latency: an/seg/dp reflect the scan index and slot count of the previous cycle (1-cycle registered latency).
- Anti-ghost blank: in any cycle where the registered slot count is 0:
  - an=111111, seg=1111111, dp=1.
  - The driven digit appears for REFRESH_DIV-1 cycles per slot.
- Otherwise an has exactly one bit low, the bit at the scan index.
- Blink counter runs 0..BLINK_DIV-1 continuously.
  - On wrap, blink phase toggles.
- Blink only matters while live alarm_active=1 (not snapshotted):
  - phase=0 forces an=111111 and dp=1.
  - phase=1 displays normally.
- When alarm_active falls, the display is visible the next cycle regardless of phase.
  - The blink counter keeps running and is not reset.
- Reset asserted mid-frame: all state returns to reset values on that edge.
  - First digit slot after release is index 0 with snapshot=0.
  - The display shows 0s (time view) from the first frame until the first snapshot load.
- Simultaneous slot wrap and blink wrap: both take effect on the same edge, with no priority interaction.

Test Plan (REFRESH_DIV=4, BLINK_DIV=16):
- Reset, then inputs 12:34:56, show_alarm=0, alarm_active=0:
  - Within the first frame, every enabled slot shows seg=1000000 (snapshot still 0).
  - From the second frame: an sequence 111110→…→011111, with each slot 1 blank cycle then 3 driven cycles.
  - seg values 6,5,4,3,2,1 decoded; dp low only on an=111011 and an=101111.
- Change min_r from 4 to 7 while scan index=1:
  - Index 2 of the same frame still shows 4 (0011001).
  - The next frame shows 7 (1111000).
- show_alarm=1 with alarm 07:45:
  - Indices 0 and 1 stay blank.
  - Index 2 seg=0010010, index 3=0011001, index 4=1111000, index 5=1000000.
- alarm_active=1:
  - an=111111 for 16 consecutive cycles, then normal scanning for 16 cycles, repeating.
  - Dropping alarm_active during an off phase restores scanning on the next cycle.
- Force sec_r=4'hC:
  - Index 0 shows seg=0111111 (dash).
- Assert rst for 1 cycle mid-slot at scan index 3:
  - The next cycle shows an=111111, seg=1111111, dp=1.
  - Scanning restarts at index 0 after a 4-cycle slot.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Six-digit common-anode seven-segment scan driver for the digital clock.
// Snapshots time/alarm digits once per frame, blanks each slot's first cycle, blinks while the alarm sounds.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_r,
  input  logic [2:0] sec_l,
  input  logic [3:0] min_r,
  input  logic [2:0] min_l,
  input  logic [3:0] hr_r,
  input  logic [1:0] hr_l,
  input  logic [1:0] alm_hr_l,
  input  logic [3:0] alm_hr_r,
  input  logic [2:0] alm_min_l,
  input  logic [3:0] alm_min_r,
  input  logic       show_alarm,
  input  logic       alarm_active,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  typedef enum logic [2:0] {
    IDX_SEC_R = 3'd0,
    IDX_SEC_L = 3'd1,
    IDX_MIN_R = 3'd2,
    IDX_MIN_L = 3'd3,
    IDX_HR_R  = 3'd4,
    IDX_HR_L  = 3'd5
  } scan_idx_t;

  typedef struct packed {
    logic [3:0] sec_r;
    logic [2:0] sec_l;
    logic [3:0] min_r;
    logic [2:0] min_l;
    logic [3:0] hr_r;
    logic [1:0] hr_l;
    logic [3:0] alm_min_r;
    logic [2:0] alm_min_l;
    logic [3:0] alm_hr_r;
    logic [1:0] alm_hr_l;
    logic       show_alarm;
  } snap_t;

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  scan_idx_t     scan_idx_q, scan_idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  snap_t         snap_q, snap_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic       slot_wrap;
  logic [3:0] digit;
  logic       alarm_blank;
  logic       drive;
  logic       visible;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q  <= '0;
      scan_idx_q  <= IDX_SEC_R;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      snap_q      <= '0;
      an_q        <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      scan_idx_q  <= scan_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  always_comb begin
    slot_wrap   = (slot_cnt_q == SW'(REFRESH_DIV - 1));
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    scan_idx_d  = scan_idx_q;
    snap_d      = snap_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    if (slot_wrap) begin
      scan_idx_d = (scan_idx_q == IDX_HR_L) ? IDX_SEC_R : scan_idx_t'(scan_idx_q + 3'd1);
      // Frame boundary: capture everything so a frame never mixes old and new digits.
      if (scan_idx_q == IDX_HR_L) begin
        snap_d.sec_r      = sec_r;
        snap_d.sec_l      = sec_l;
        snap_d.min_r      = min_r;
        snap_d.min_l      = min_l;
        snap_d.hr_r       = hr_r;
        snap_d.hr_l       = hr_l;
        snap_d.alm_min_r  = alm_min_r;
        snap_d.alm_min_l  = alm_min_l;
        snap_d.alm_hr_r   = alm_hr_r;
        snap_d.alm_hr_l   = alm_hr_l;
        snap_d.show_alarm = show_alarm;
      end
    end
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_comb begin
    digit       = '0;
    alarm_blank = 1'b0;
    case (scan_idx_q)
      IDX_SEC_R: begin
        digit       = snap_q.sec_r;
        alarm_blank = snap_q.show_alarm;
      end
      IDX_SEC_L: begin
        digit       = {1'b0, snap_q.sec_l};
        alarm_blank = snap_q.show_alarm;
      end
      IDX_MIN_R: digit = snap_q.show_alarm ? snap_q.alm_min_r : snap_q.min_r;
      IDX_MIN_L: digit = snap_q.show_alarm ? {1'b0, snap_q.alm_min_l} : {1'b0, snap_q.min_l};
      IDX_HR_R:  digit = snap_q.show_alarm ? snap_q.alm_hr_r : snap_q.hr_r;
      IDX_HR_L:  digit = snap_q.show_alarm ? {2'b00, snap_q.alm_hr_l} : {2'b00, snap_q.hr_l};
      default:   digit = '0;
    endcase

    // Slot count 0 is the anti-ghost gap; blink only gates the anodes and dp.
    drive   = (slot_cnt_q != '0) && !alarm_blank;
    visible = !(alarm_active && !blink_ph_q);

    an_d  = (drive && visible) ? ~(6'b000001 << scan_idx_q) : '1;
    seg_d = drive ? decode(digit) : '1;
    dp_d  = !(drive && visible && (scan_idx_q == IDX_MIN_R || scan_idx_q == IDX_HR_R));
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
